// File: rtl/rv32m_sched.sv
// rtl/rv32m_sched.sv - two-requester round-robin scheduler for a shared multi-cycle rv32m unit
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   req0_*/req1_*                 requester handshakes (valid/ready) with rs1, rs2, funct3
//   resp0_*/resp1_*               one-cycle result pulse plus held rd/error/timeout
//   m_rst, m_in_valid, m_rs1,
//   m_rs2, m_funct3               registered drive of the shared unit
//   m_rd, m_out_valid, m_in_error result from the shared unit
//   busy                          high whenever an operation is in flight
//   owner                         requester currently (or most recently) granted

module rv32m_sched #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_rs1,
    input  logic [N-1:0] req0_rs2,
    input  logic [2:0]   req0_funct3,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_rs1,
    input  logic [N-1:0] req1_rs2,
    input  logic [2:0]   req1_funct3,

    output logic         resp0_valid,
    output logic [N-1:0] resp0_rd,
    output logic         resp0_error,
    output logic         resp0_timeout,

    output logic         resp1_valid,
    output logic [N-1:0] resp1_rd,
    output logic         resp1_error,
    output logic         resp1_timeout,

    output logic         m_rst,
    output logic         m_in_valid,
    output logic [N-1:0] m_rs1,
    output logic [N-1:0] m_rs2,
    output logic [2:0]   m_funct3,
    input  logic [N-1:0] m_rd,
    input  logic         m_out_valid,
    input  logic         m_in_error,

    output logic         busy,
    output logic         owner
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_UNIT,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            grant_idx;
    logic            grant_any;
    logic            in_idle;
    logic            accept;
    logic            expired;
    logic            wait_done;

    assign in_idle   = (state == S_IDLE);
    assign grant_any = req0_valid | req1_valid;
    assign accept    = in_idle & grant_any;
    assign expired   = (cnt == CW'(TIMEOUT - 1));
    // A result arriving on the expiry cycle still counts as a result.
    assign wait_done = (state == S_WAIT) & (m_out_valid | expired);

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_idx = ~owner;
        end else if (req1_valid) begin
            grant_idx = 1'b1;
        end
    end

    assign req0_ready = in_idle & req0_valid & ~grant_idx;
    assign req1_ready = in_idle & req1_valid &  grant_idx;

    assign busy        = ~in_idle;
    assign resp0_valid = (state == S_RESP) & ~owner;
    assign resp1_valid = (state == S_RESP) &  owner;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_RST_UNIT;
            S_RST_UNIT: state_nxt = S_LAUNCH;
            S_LAUNCH:   state_nxt = S_WAIT;
            S_WAIT:     if (m_out_valid || expired) state_nxt = S_RESP;
            S_RESP:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            owner         <= 1'b1;
            m_rst         <= 1'b1;
            m_in_valid    <= 1'b0;
            m_rs1         <= '0;
            m_rs2         <= '0;
            m_funct3      <= '0;
            resp0_rd      <= '0;
            resp0_error   <= 1'b0;
            resp0_timeout <= 1'b0;
            resp1_rd      <= '0;
            resp1_error   <= 1'b0;
            resp1_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Unit controls are registered from the next state so each is a
            // clean one-cycle pulse aligned with RST_UNIT / LAUNCH.
            m_rst      <= (state_nxt == S_RST_UNIT);
            m_in_valid <= (state_nxt == S_LAUNCH);
            cnt        <= (state == S_WAIT) ? cnt + CW'(1) : '0;

            if (accept) begin
                owner    <= grant_idx;
                m_rs1    <= grant_idx ? req1_rs1    : req0_rs1;
                m_rs2    <= grant_idx ? req1_rs2    : req0_rs2;
                m_funct3 <= grant_idx ? req1_funct3 : req0_funct3;
            end

            // The owner's result registers are written on WAIT exit and then
            // hold until that requester's next response.
            if (wait_done) begin
                if (owner) begin
                    resp1_rd      <= m_out_valid ? m_rd : '0;
                    resp1_error   <= m_out_valid & m_in_error;
                    resp1_timeout <= ~m_out_valid;
                end else begin
                    resp0_rd      <= m_out_valid ? m_rd : '0;
                    resp0_error   <= m_out_valid & m_in_error;
                    resp0_timeout <= ~m_out_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32m_sched.sv
// tb/tb_rv32m_sched.sv - self-checking bench for rv32m_sched

module tb_rv32m_sched;

    localparam int N  = 32;
    localparam int TO = 64;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic        idx;
        logic [31:0] rd;
        logic        err;
        logic        to;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]  req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [2:0]    req0_funct3, req1_funct3;
    logic          resp0_valid, resp0_error, resp0_timeout;
    logic          resp1_valid, resp1_error, resp1_timeout;
    logic [N-1:0]  resp0_rd, resp1_rd;
    logic          m_rst, m_in_valid, m_out_valid, m_in_error;
    logic [N-1:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]    m_funct3;
    logic          busy, owner;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_mode = 0;
    int            model_lat = 1;
    int            rst_cyc = -100;
    int            launch_cyc = -100;
    logic          acc0 = 1'b0;
    logic          acc1 = 1'b0;
    logic [31:0]   mres;
    exp_t          sb[$];
    op_t           q0[$];
    op_t           q1[$];
    int            grants[$];

    rv32m_sched #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_funct3(req0_funct3),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_funct3(req1_funct3),
        .resp0_valid(resp0_valid), .resp0_rd(resp0_rd), .resp0_error(resp0_error),
        .resp0_timeout(resp0_timeout),
        .resp1_valid(resp1_valid), .resp1_rd(resp1_rd), .resp1_error(resp1_error),
        .resp1_timeout(resp1_timeout),
        .m_rst(m_rst), .m_in_valid(m_in_valid), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_funct3(m_funct3), .m_rd(m_rd), .m_out_valid(m_out_valid),
        .m_in_error(m_in_error), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (f)
            3'b000: p = {32'b0, a} * {32'b0, b};
            3'b001: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b010: p = {{32{a[31]}}, a} * {32'b0, b};
            3'b011: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        case (f)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $unsigned($signed(a) / $signed(b));
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $unsigned($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural stand-in for the rv32m unit.
    // mode 0: answer model_lat cycles after launch; mode 1: never answer;
    // mode 2: hold a stale out_valid through RST_UNIT/LAUNCH, then a div-by-0 error.
    initial begin
        m_out_valid = 1'b0;
        m_rd        = '0;
        m_in_error  = 1'b0;
        forever begin
            @(negedge clk);
            if (model_mode == 0 && m_in_valid) begin
                mres = ref_op(m_funct3, m_rs1, m_rs2);
                repeat (model_lat) @(negedge clk);
                m_out_valid = 1'b1;
                m_rd        = mres;
                @(negedge clk);
                m_out_valid = 1'b0;
                m_rd        = '0;
            end else if (model_mode == 2 && m_rst && busy) begin
                m_out_valid = 1'b1;
                m_rd        = 32'hDEAD_BEEF;
                @(negedge clk);
                @(negedge clk);
                m_rd        = 32'hFFFF_FFFF;
                m_in_error  = 1'b1;
                @(negedge clk);
                m_out_valid = 1'b0;
                m_in_error  = 1'b0;
                m_rd        = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t exp_of(input logic idx, input op_t o);
        exp_t e;
        e.idx = idx;
        e.acc_cyc = cyc;
        e.err = 1'b0;
        e.to  = 1'b0;
        if (model_mode == 1) begin
            e.rd = '0; e.to = 1'b1; e.lat = 3 + TO;
        end else if (model_mode == 2) begin
            e.rd = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = 4;
        end else begin
            e.rd = ref_op(o.f3, o.a, o.b); e.lat = 3 + model_lat;
        end
        return e;
    endfunction

    task automatic load0(input op_t o);
        req0_valid = 1'b1; req0_rs1 = o.a; req0_rs2 = o.b; req0_funct3 = o.f3;
    endtask

    task automatic load1(input op_t o);
        req1_valid = 1'b1; req1_rs1 = o.a; req1_rs2 = o.b; req1_funct3 = o.f3;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (acc0) begin
            acc0 = 1'b0;
            if (q0.size() > 0) load0(q0.pop_front()); else req0_valid = 1'b0;
        end
        if (acc1) begin
            acc1 = 1'b0;
            if (q1.size() > 0) load1(q1.pop_front()); else req1_valid = 1'b0;
        end
        if (!req0_valid && q0.size() > 0) load0(q0.pop_front());
        if (!req1_valid && q1.size() > 0) load1(q1.pop_front());
        #1;
        if (m_rst && busy) rst_cyc = cyc;
        if (m_in_valid) launch_cyc = cyc;
        if (resp0_valid || resp1_valid) begin
            check("resp_onehot", 32'(resp0_valid & resp1_valid), 32'd0);
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_idx", 32'(resp1_valid), 32'(e.idx));
                check("resp_owner", 32'(owner), 32'(e.idx));
                check("resp_rd", resp1_valid ? resp1_rd : resp0_rd, e.rd);
                check("resp_error", 32'(resp1_valid ? resp1_error : resp0_error), 32'(e.err));
                check("resp_timeout", 32'(resp1_valid ? resp1_timeout : resp0_timeout), 32'(e.to));
                check("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                check("m_rst_slot", 32'(rst_cyc - e.acc_cyc), 32'd1);
                check("m_in_valid_slot", 32'(launch_cyc - e.acc_cyc), 32'd2);
            end
        end
        if (req0_valid && req1_valid)
            check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        if (req0_valid && req0_ready) begin
            sb.push_back(exp_of(1'b0, '{req0_funct3, req0_rs1, req0_rs2}));
            grants.push_back(0);
            acc0 = 1'b1;
        end
        if (req1_valid && req1_ready) begin
            sb.push_back(exp_of(1'b1, '{req1_funct3, req1_rs1, req1_rs2}));
            grants.push_back(1);
            acc1 = 1'b1;
        end
    endtask

    function automatic logic all_done();
        return q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid
            && !acc0 && !acc1 && sb.size() == 0;
    endfunction

    task automatic run(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (all_done()) break;
            step();
        end
        check("run_done", 32'(all_done()), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_rs1 = '0; req0_rs2 = '0; req0_funct3 = '0;
        req1_valid = 1'b0; req1_rs1 = '0; req1_rs2 = '0; req1_funct3 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_rst", 32'(m_rst), 32'd1);
        check("rst_m_in_valid", 32'(m_in_valid), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        check("rst_m_rs1", m_rs1, 32'd0);
        check("rst_m_funct3", 32'(m_funct3), 32'd0);
        check("rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
        check("rst_resp0_rd", resp0_rd, 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_m_rst", 32'(m_rst), 32'd0);

        // single op: 7*6
        model_mode = 0; model_lat = 1;
        q0.push_back('{3'b000, 32'd7, 32'd6});
        run(40);
        check("single_owner", 32'(owner), 32'd0);

        // tie after reset: req0 divu 100/7, req1 remu 100/7
        do_reset();
        grants.delete();
        model_lat = 2;
        q0.push_back('{3'b101, 32'd100, 32'd7});
        q1.push_back('{3'b111, 32'd100, 32'd7});
        run(60);
        check("tie_grants", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            check("tie_first", 32'(grants[0]), 32'd0);
            check("tie_second", 32'(grants[1]), 32'd1);
        end

        // fairness: both queues of 4 ops, req0 held valid continuously
        grants.delete();
        model_lat = 1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{3'(i), $urandom, $urandom_range(1, 1000)});
            q1.push_back('{3'(i + 4), $urandom, $urandom_range(1, 1000)});
        end
        run(200);
        check("fair_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size(); i++)
            check("fair_alternate", 32'(grants[i]), 32'(i % 2));

        // watchdog expiry, then a normal op
        model_mode = 1;
        q0.push_back('{3'b000, 32'd3, 32'd3});
        run(120);
        model_mode = 0;
        q0.push_back('{3'b000, 32'd3, 32'd3});
        run(40);
        check("post_timeout_rd", resp0_rd, 32'd9);
        check("post_timeout_flag", 32'(resp0_timeout), 32'd0);

        // stale out_valid ignored, then div-by-zero error
        model_mode = 2;
        q1.push_back('{3'b101, 32'd5, 32'd0});
        run(40);

        // reset in the middle of WAIT
        model_mode = 1;
        q0.push_back('{3'b000, 32'd3, 32'd4});
        for (int i = 0; i < 8; i++) step();
        check("midwait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_m_rst", 32'(m_rst), 32'd1);
        check("midrst_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
        check("midrst_owner", 32'(owner), 32'd1);
        sb.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        req0_valid = 1'b0;
        model_mode = 0;
        rst = 1'b1;
        load1('{3'b011, 32'hFFFF_FFFF, 32'd2});
        #1;
        check("first_idle_ready", 32'(req1_ready), 32'd1);
        if (req1_ready) begin
            sb.push_back(exp_of(1'b1, '{req1_funct3, req1_rs1, req1_rs2}));
            acc1 = 1'b1;
        end
        run(40);
        check("after_reset_rd", resp1_rd, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32m_sched.md
Name: rv32m_sched

Overview:
- Shares one multi-cycle rv32m multiply/divide unit between two requesters (req0, req1), e.g. two issue slots.
- Round-robin arbitration; registers operands on accept; resets and launches the unit; waits for out_valid or a watchdog timeout; routes the result back to the owning requester.
- Sits between the issue logic and the rv32m instance and is the only driver of the unit's inputs.

Parameters:
- N, 32, operand/result width.
- TIMEOUT, 64, WAIT-state cycles allowed before the operation is abandoned (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
- req0_rs1, req0_rs2  in  N  operands.
- req0_funct3  in  3  RV32M op (000 mul … 111 remu).
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_funct3  same roles for requester 1.
- resp0_valid  out  1  one-cycle result pulse to requester 0.
- resp0_rd  out  N  result.
- resp0_error  out  1  unit in_error captured with result.
- resp0_timeout  out  1  watchdog expired; rd forced 0.
- resp1_valid, resp1_rd, resp1_error, resp1_timeout  same for requester 1.
- m_rst  out  1  active-high reset to rv32m unit.
- m_in_valid  out  1  launch pulse to unit.
- m_rs1, m_rs2  out  N  registered operands to unit.
- m_funct3  out  3  registered op to unit.
- m_rd  in  N  unit result.
- m_out_valid  in  1  unit result valid.
- m_in_error  in  1  unit error flag.
- busy  out  1  high in any state except IDLE.
- owner  out  1  index of the current or last granted requester.

Behaviour:
- Reset (rst=0 at edge): state IDLE; all resp*/ready/m_in_valid/busy = 0; m_rs1/m_rs2/m_funct3 = 0; m_rst = 1; owner = 1, so req0 wins the first tie; timeout counter = 0. Reset mid-operation abandons the operation; no response is issued.
- m_rst is registered: 1 during reset and in RST_UNIT, 0 elsewhere.
- FSM states: IDLE → RST_UNIT → LAUNCH → WAIT → RESP → IDLE.
- IDLE: grant is combinational from the valids. Only one valid: grant it. Both valid: grant the index ≠ owner. reqX_ready = 1 only for the granted index, and only in IDLE. On handshake at edge T: capture rs1/rs2/funct3 into the m_* registers, set owner, go to RST_UNIT.
- RST_UNIT (T+1): m_rst = 1 for exactly one cycle.
- LAUNCH (T+2): m_in_valid = 1 for exactly one cycle.
- WAIT (from T+3): counter increments each cycle.
  - First cycle with m_out_valid = 1: latch m_rd and m_in_error, go to RESP.
  - m_out_valid before WAIT is ignored as stale.
  - Counter reaching TIMEOUT with no m_out_valid: go to RESP with timeout flag set, rd = 0, error = 0.
  - m_out_valid on the same edge as expiry: the result wins; timeout = 0.
- RESP: resp[owner]_valid = 1 for one cycle with latched rd/error/timeout. The other resp valid stays 0. Next state is IDLE.
  - No response backpressure; requesters must accept the pulse.
  - resp*_rd/error/timeout hold their values until the next RESP.
- m_rs1/m_rs2/m_funct3 are stable from RST_UNIT through RESP.
- Requests are never accepted outside IDLE. A requester's valid and operands must stay stable until ready.
- Best-case accept-to-response: m_out_valid at cycle W gives resp_valid at W+1. Min issue interval is 5 cycles.

Test Plan:
- Single op: req0 mul rs1=7, rs2=6 → m_rst pulse at T+1, m_in_valid at T+2; resp0_valid one cycle after m_out_valid with rd=0x0000002A. resp1_valid stays 0.
- Tie: req0 and req1 valid together after reset (req0 divu 100/7, req1 remu 100/7) → req0 served first with rd=14, then req1 with rd=2. owner toggles 0→1.
- Fairness: req0 held valid continuously and req1 valid → grants alternate 0,1,0,1; neither requester is starved across 8 ops.
- Timeout: unit model never asserts out_valid, TIMEOUT=64 → resp valid exactly 64 WAIT cycles after entry, timeout=1, rd=0. The next op completes normally.
- Error/stale: m_out_valid held high during RST_UNIT/LAUNCH is ignored. In WAIT, m_in_error=1 with rd=0xFFFFFFFF (div by 0) → resp error=1, rd=0xFFFFFFFF.
- Reset mid-WAIT: rst=0 for 1 cycle → busy=0, m_rst=1, no resp pulse. The next request is accepted in the first IDLE cycle.
